// File: rtl/booth_request_scheduler.sv
// Request scheduler in front of the Booth multiplier: queues operand pairs,
// issues them one at a time, bounds the wait for completion, returns tagged results.
module booth_request_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MIN_LAT = 11,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                       gated_clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [7:0]                 req_a,
    input  logic [7:0]                 req_b,
    input  logic [1:0]                 req_mode,
    output logic                       mul_start,
    output logic [7:0]                 mul_multiplicand,
    output logic [7:0]                 mul_multiplier,
    output logic [1:0]                 mul_power_mode,
    input  logic                       mul_done,
    input  logic [15:0]                mul_product,
    input  logic [7:0]                 mul_power,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [15:0]                rsp_product,
    output logic [7:0]                 rsp_power,
    output logic [3:0]                 rsp_tag,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    req_t            mem_q [DEPTH];
    req_t            head;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [3:0]      tag_q, tag_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop, accept;

    logic            mul_start_q, mul_start_d;
    logic [7:0]      mul_a_q, mul_a_d;
    logic [7:0]      mul_b_q, mul_b_d;
    logic [1:0]      mul_mode_q, mul_mode_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_product_q, rsp_product_d;
    logic [7:0]      rsp_power_q, rsp_power_d;
    logic [3:0]      rsp_tag_q, rsp_tag_d;
    logic            rsp_err_q, rsp_err_d;

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign req_ready = !reset && (level_q < LW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign head      = mem_q[rd_ptr_q];
    assign level_d   = level_q + LW'(push) - LW'(pop);
    assign accept    = (cnt_q >= CW'(MIN_LAT)) && mul_done;

    always_ff @(posedge gated_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_a, req_b, req_mode};
        end
    end

    // Next-state and registered-output logic; ISSUE is the only state that pops.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        pop           = 1'b0;
        mul_start_d   = 1'b0;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_mode_d    = mul_mode_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_product_d = rsp_product_q;
        rsp_power_d   = rsp_power_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_err_d     = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pop         = 1'b1;
                mul_a_d     = head.a;
                mul_b_d     = head.b;
                mul_mode_d  = head.mode;
                mul_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (cnt_q < CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Acceptance is checked first so it wins over a coincident timeout.
                if (accept) begin
                    rsp_valid_d   = 1'b1;
                    rsp_product_d = mul_product;
                    rsp_power_d   = mul_power;
                    rsp_tag_d     = tag_q;
                    rsp_err_d     = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q >= CW'(TIMEOUT)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_product_d = '0;
                    rsp_power_d   = '0;
                    rsp_tag_d     = tag_q;
                    rsp_err_d     = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    tag_d       = tag_q + 4'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge gated_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            tag_q         <= '0;
            cnt_q         <= '0;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_mode_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_product_q <= '0;
            rsp_power_q   <= '0;
            rsp_tag_q     <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q       <= level_d;
            tag_q         <= tag_d;
            cnt_q         <= cnt_d;
            mul_start_q   <= mul_start_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_mode_q    <= mul_mode_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            rsp_power_q   <= rsp_power_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign mul_start        = mul_start_q;
    assign mul_multiplicand = mul_a_q;
    assign mul_multiplier   = mul_b_q;
    assign mul_power_mode   = mul_mode_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_product      = rsp_product_q;
    assign rsp_power        = rsp_power_q;
    assign rsp_tag          = rsp_tag_q;
    assign rsp_err          = rsp_err_q;
    assign fifo_level       = level_q;
    assign busy             = (level_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_booth_request_scheduler.sv
// Directed bench for booth_request_scheduler with a behavioural multiplier
// whose done/product timing is selectable per step.
module tb_booth_request_scheduler;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MIN_LAT = 11;
    localparam int unsigned TIMEOUT = 32;

    logic        gated_clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [1:0]  req_mode;
    logic        mul_start;
    logic [7:0]  mul_multiplicand;
    logic [7:0]  mul_multiplier;
    logic [1:0]  mul_power_mode;
    logic        mul_done    = 1'b0;
    logic [15:0] mul_product = 16'h0;
    logic [7:0]  mul_power   = 8'h0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_product;
    logic [7:0]  rsp_power;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic [2:0]  fifo_level;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // 0: done rises at MIN_LAT, 1: never done, 2: done stuck high, product valid from MIN_LAT
    int         model_mode = 0;
    int         k = 0;
    logic [7:0] ma = 8'h0;
    logic [7:0] mb = 8'h0;
    logic [1:0] mm = 2'd0;

    booth_request_scheduler #(
        .DEPTH(DEPTH), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .gated_clk(gated_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_power_mode(mul_power_mode),
        .mul_done(mul_done), .mul_product(mul_product), .mul_power(mul_power),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .rsp_power(rsp_power),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .fifo_level(fifo_level), .busy(busy)
    );

    always #5 gated_clk = ~gated_clk;

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] xa;
        logic [15:0] xb;
        xa = {{8{a[7]}}, a};
        xb = {{8{b[7]}}, b};
        return xa * xb;
    endfunction

    function automatic logic [7:0] pwr(input logic [1:0] m);
        case (m)
            2'd0:    return 8'd9;
            2'd1:    return 8'd5;
            2'd2:    return 8'd2;
            default: return 8'd1;
        endcase
    endfunction

    // Multiplier model: k counts cycles since the start pulse (0 in the start cycle).
    always @(negedge gated_clk) begin
        if (mul_start === 1'b1) begin
            k  = 0;
            ma = mul_multiplicand;
            mb = mul_multiplier;
            mm = mul_power_mode;
        end else if (k < 1000) begin
            k = k + 1;
        end
        case (model_mode)
            1: begin
                mul_done    = 1'b0;
                mul_product = 16'hBAD0;
            end
            2: begin
                mul_done    = 1'b1;
                mul_product = (k >= int'(MIN_LAT)) ? prod(ma, mb) : 16'h7777;
            end
            default: begin
                mul_done    = (k >= int'(MIN_LAT));
                mul_product = (k >= int'(MIN_LAT)) ? prod(ma, mb) : 16'hDEAD;
            end
        endcase
        mul_power = pwr(mm);
    end

    task automatic tick();
        @(negedge gated_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        output logic acc);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_mode  = m;
        acc       = req_ready;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (mul_start !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(mul_start), 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input logic [15:0] p, input logic [7:0] pw,
                              input logic [3:0] tg, input logic er, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_valid"},   32'(rsp_valid),   32'd1);
        chk({tag, "_product"}, 32'(rsp_product), 32'(p));
        chk({tag, "_power"},   32'(rsp_power),   32'(pw));
        chk({tag, "_tag"},     32'(rsp_tag),     32'(tg));
        chk({tag, "_err"},     32'(rsp_err),     32'(er));
        if (rsp_ready === 1'b1) begin
            tick();
        end
    endtask

    initial begin
        logic acc;
        logic ok;
        int   n;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = 8'h0;
        req_b     = 8'h0;
        req_mode  = 2'd0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rst_mul_start", 32'(mul_start),  32'd0);
        chk("rst_level",     32'(fifo_level), 32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_req_ready", 32'(req_ready),  32'd0);
        chk("rst_tag",       32'(rsp_tag),    32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Single request, nominal latency
        rsp_ready  = 1'b1;
        model_mode = 0;
        push(8'd5, 8'd3, 2'd0, acc);
        wait_start("t1_start");
        chk("t1_mul_a", 32'(mul_multiplicand), 32'd5);
        chk("t1_mul_b", 32'(mul_multiplier),   32'd3);
        expect_rsp("t1", 16'd15, 8'd9, 4'd0, 1'b0, n);
        chk("t1_latency", 32'(n), 32'd12);
        chk("t1_valid_drop", 32'(rsp_valid), 32'd0);

        // Fill FIFO while the FSM is parked in RESP
        rsp_ready = 1'b0;
        push(8'hFB, 8'h03, 2'd1, acc);
        expect_rsp("t2_p0", 16'hFFF1, 8'd5, 4'd1, 1'b0, n);
        push(8'hFB, 8'hFD, 2'd2, acc);  chk("t2_acc1", 32'(acc), 32'd1);
        push(8'h07, 8'h09, 2'd0, acc);  chk("t2_acc2", 32'(acc), 32'd1);
        push(8'h80, 8'h80, 2'd1, acc);  chk("t2_acc3", 32'(acc), 32'd1);
        push(8'h7F, 8'h80, 2'd0, acc);  chk("t2_acc4", 32'(acc), 32'd1);
        push(8'h01, 8'h01, 2'd0, acc);  chk("t2_acc5_refused", 32'(acc), 32'd0);
        chk("t2_level_full", 32'(fifo_level), 32'd4);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_product !== 16'hFFF1 || rsp_tag !== 4'd1 ||
                mul_start !== 1'b0 || fifo_level !== 3'd4) ok = 1'b0;
        end
        chk("t5_hold_stable", 32'(ok), 32'd1);
        rsp_ready = 1'b1;
        expect_rsp("t2_r0", 16'hFFF1, 8'd5, 4'd1, 1'b0, n);
        expect_rsp("t2_r1", 16'h000F, 8'd2, 4'd2, 1'b0, n);
        expect_rsp("t2_r2", 16'h003F, 8'd9, 4'd3, 1'b0, n);
        expect_rsp("t2_r3", 16'h4000, 8'd5, 4'd4, 1'b0, n);
        expect_rsp("t2_r4", 16'hC080, 8'd9, 4'd5, 1'b0, n);

        // Done stuck high: nothing may be taken before MIN_LAT
        model_mode = 2;
        push(8'd6, 8'hF9, 2'd0, acc);
        wait_start("t3_start");
        expect_rsp("t3", 16'hFFD6, 8'd9, 4'd6, 1'b0, n);
        chk("t3_latency", 32'(n), 32'd12);

        // Timeout, then the queued request completes normally
        model_mode = 1;
        push(8'd3, 8'd4, 2'd1, acc);
        push(8'd2, 8'd2, 2'd0, acc);
        wait_start("t4_start");
        expect_rsp("t4_to", 16'h0000, 8'd0, 4'd7, 1'b1, n);
        chk("t4_latency", 32'(n), 32'(TIMEOUT + 1));
        model_mode = 0;
        wait_start("t4_next_start");
        chk("t4_next_mul_a", 32'(mul_multiplicand), 32'd2);
        expect_rsp("t4_next", 16'd4, 8'd9, 4'd8, 1'b0, n);

        // Reset in WAIT with two entries queued
        push(8'd1, 8'd2, 2'd0, acc);
        push(8'd3, 8'd3, 2'd0, acc);
        push(8'd4, 8'd4, 2'd0, acc);
        wait_start("t6_start");
        repeat (3) tick();
        chk("t6_level_pre", 32'(fifo_level), 32'd2);
        chk("t6_busy_pre",  32'(busy),       32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(rsp_valid),        32'd0);
        chk("t6_rst_start", 32'(mul_start),        32'd0);
        chk("t6_rst_mul_a", 32'(mul_multiplicand), 32'd0);
        chk("t6_rst_level", 32'(fifo_level),       32'd0);
        chk("t6_rst_busy",  32'(busy),             32'd0);
        repeat (2) tick();
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || mul_start !== 1'b0) ok = 1'b0;
        end
        chk("t6_no_activity", 32'(ok), 32'd1);
        push(8'd9, 8'd9, 2'd0, acc);
        wait_start("t6_new_start");
        expect_rsp("t6_new", 16'd81, 8'd9, 4'd0, 1'b0, n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
